// File: rtl/lane_judge.sv
// lane_judge: judges player key presses against the 3-lane pattern shown for
// each beat, emitting registered hit/miss pulses and keeping a saturating
// score and a combo counter for the HEX display logic.
module lane_judge #(
  parameter int WINDOW  = 8,
  parameter int SCORE_W = 10,
  parameter int COMBO_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         pattern,
  input  logic               tick,
  input  logic [2:0]         keys,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic               judging
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Window counter loads WINDOW-1 so that a beat accepts edges for exactly
  // WINDOW cycles after the tick and times out WINDOW+1 cycles after it.
  localparam logic [7:0] CNT_INIT = 8'(WINDOW - 1);

  localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};
  localparam logic [COMBO_W-1:0] COMBO_ONE = {{(COMBO_W-1){1'b0}}, 1'b1};

  logic [1:0] state;
  logic [1:0] state_next;
  logic [2:0] target;
  logic [2:0] target_next;
  logic [2:0] acc;
  logic [2:0] acc_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic [2:0] keys_prev;
  logic [2:0] edges;
  logic [2:0] nacc;
  logic       target_legal;
  logic       stray;
  logic       complete;
  logic       judge_hit;
  logic       judge_miss;

  // Only fresh presses count; a key held across a tick gives no edge.
  assign edges = keys & ~keys_prev;

  // Lanes pressed so far for the armed beat, including this cycle's edges.
  assign nacc = acc | edges;

  // Any pressed lane outside the target spoils the beat immediately.
  assign stray = |(nacc & ~target);

  // An illegal target can never be completed, so such a beat always ends
  // in a miss (by timeout, stray press or the next tick).
  assign complete = target_legal && (nacc == target);

  // Recognise the four patterns the light generator is allowed to show.
  always_comb begin
    target_legal = 1'b0;
    case (target)
      3'b101, 3'b001, 3'b100, 3'b010: target_legal = 1'b1;
      default:                        target_legal = 1'b0;
    endcase
  end

  // Judge the armed beat, then let a tick arm the next beat on top of it.
  always_comb begin
    state_next  = state;
    target_next = target;
    acc_next    = acc;
    cnt_next    = cnt;
    judge_hit   = 1'b0;
    judge_miss  = 1'b0;

    case (state)
      ARMED: begin
        if (stray) begin
          judge_miss = 1'b1;
        end else if (complete) begin
          judge_hit = 1'b1;
        end else if (tick || (cnt == 8'd0)) begin
          // A new beat arriving closes the old one; incomplete means miss.
          judge_miss = 1'b1;
        end

        if (judge_hit || judge_miss) begin
          state_next = DONE;
        end else begin
          acc_next = nacc;
          cnt_next = cnt - 8'd1;
        end
      end
      IDLE, DONE: begin
        state_next = state;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (tick) begin
      state_next  = ARMED;
      target_next = pattern;
      acc_next    = 3'b000;
      cnt_next    = CNT_INIT;
    end
  end

  // Beat FSM and its per-beat bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      target <= 3'b000;
      acc    <= 3'b000;
      cnt    <= 8'd0;
    end else begin
      state  <= state_next;
      target <= target_next;
      acc    <= acc_next;
      cnt    <= cnt_next;
    end
  end

  // Key history for edge detection, tracked in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keys_prev <= 3'b000;
    end else begin
      keys_prev <= keys;
    end
  end

  // Registered one-cycle verdict pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit  <= 1'b0;
      miss <= 1'b0;
    end else begin
      hit  <= judge_hit;
      miss <= judge_miss;
    end
  end

  // Saturating score, counting every hit ever made.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score <= '0;
    end else if (judge_hit && !(&score)) begin
      score <= score + SCORE_ONE;
    end
  end

  // Saturating combo, cleared by any miss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      combo <= '0;
    end else if (judge_miss) begin
      combo <= '0;
    end else if (judge_hit && !(&combo)) begin
      combo <= combo + COMBO_ONE;
    end
  end

  assign judging = (state == ARMED);

endmodule

// File: tb/tb_lane_judge.sv
// tb_lane_judge: table-driven vectors plus hand-written multi-cycle
// sequences; every expected verdict is queued when its beat is driven and
// compared when the DUT pulses hit or miss.
module tb_lane_judge;

  localparam int WINDOW    = 8;
  localparam int SCORE_W   = 10;
  localparam int COMBO_W   = 8;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;
  localparam int COMBO_MAX = (1 << COMBO_W) - 1;

  typedef struct {
    logic [2:0] pat;
    logic [2:0] k1;
    int         d1;
    logic [2:0] k2;
    int         d2;
    logic       exp_hit;
    int         lat;
  } vec_t;

  typedef struct {
    logic is_hit;
    int   cyc;
    int   score;
    int   combo;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [2:0]         pattern = 3'b000;
  logic               tick = 1'b0;
  logic [2:0]         keys = 3'b000;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic               judging;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_score = 0;
  int   exp_combo = 0;
  exp_t sb[$];
  vec_t vecs[13];

  lane_judge #(
    .WINDOW (WINDOW),
    .SCORE_W(SCORE_W),
    .COMBO_W(COMBO_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pattern(pattern),
    .tick   (tick),
    .keys   (keys),
    .hit    (hit),
    .miss   (miss),
    .score  (score),
    .combo  (combo),
    .judging(judging)
  );

  // Free-running clock and cycle index used to time the verdicts.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue a verdict due in cycle at_cyc and advance the expected counters.
  task automatic pushExpect(input logic is_hit, input int at_cyc);
    exp_t e;
    if (is_hit) begin
      if (exp_score < SCORE_MAX) exp_score++;
      if (exp_combo < COMBO_MAX) exp_combo++;
    end else begin
      exp_combo = 0;
    end
    e.is_hit = is_hit;
    e.cyc    = at_cyc;
    e.score  = exp_score;
    e.combo  = exp_combo;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every pulse must match the oldest queued verdict.
  always @(negedge clk) begin
    if (reset && (hit || miss)) begin
      checkOutput("hit_miss_exclusive", {31'd0, hit & miss}, 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_pulse: got hit=%0b miss=%0b, expected none (cycle %0d)",
                 hit, miss, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("verdict_is_hit", {31'd0, hit}, {31'd0, e.is_hit});
        checkOutput("verdict_cycle", cyc, e.cyc);
        checkOutput("score", {22'd0, score}, e.score);
        checkOutput("combo", {24'd0, combo}, e.combo);
      end
    end
  end

  // One table beat: tick, follow the key script for 12 cycles, release.
  task automatic applyStimulus(input vec_t v, input int idx);
    int t0;
    step();
    tick    = 1'b1;
    pattern = v.pat;
    keys    = 3'b000;
    t0      = cyc;
    pushExpect(v.exp_hit, t0 + v.lat);
    for (int d = 1; d <= 12; d++) begin
      step();
      tick = 1'b0;
      if (v.d2 != 0 && d >= v.d2)      keys = v.k2;
      else if (v.d1 != 0 && d >= v.d1) keys = v.k1;
      else                             keys = 3'b000;
      if (d == 1) checkOutput($sformatf("vec%0d_judging_armed", idx), {31'd0, judging}, 32'd1);
    end
    step();
    keys = 3'b000;
    step();
    checkOutput($sformatf("vec%0d_judging_after", idx), {31'd0, judging}, 32'd0);
  endtask

  // Back-to-back quick hits on pattern 010, two cycles each.
  task automatic fastHits(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      tick    = 1'b1;
      pattern = 3'b010;
      keys    = 3'b000;
      pushExpect(1'b1, cyc + 2);
      step();
      tick = 1'b0;
      keys = 3'b010;
    end
    step();
    keys = 3'b000;
    step();
  endtask

  initial begin
    int t0;
    int t1;

    //            pat     k1      d1  k2      d2  hit   lat
    vecs[0]  = '{3'b010, 3'b010, 2, 3'b000, 0, 1'b1, 3};
    vecs[1]  = '{3'b101, 3'b100, 1, 3'b101, 2, 1'b1, 3};
    vecs[2]  = '{3'b001, 3'b000, 0, 3'b000, 0, 1'b0, WINDOW + 1};
    vecs[3]  = '{3'b100, 3'b010, 1, 3'b110, 3, 1'b0, 2};
    vecs[4]  = '{3'b101, 3'b101, 1, 3'b000, 0, 1'b1, 2};
    vecs[5]  = '{3'b101, 3'b001, 1, 3'b011, 2, 1'b0, 3};
    vecs[6]  = '{3'b010, 3'b010, 8, 3'b000, 0, 1'b1, 9};
    vecs[7]  = '{3'b010, 3'b010, 9, 3'b000, 0, 1'b0, 9};
    vecs[8]  = '{3'b111, 3'b111, 1, 3'b000, 0, 1'b0, 9};
    vecs[9]  = '{3'b000, 3'b000, 0, 3'b000, 0, 1'b0, 9};
    vecs[10] = '{3'b001, 3'b011, 1, 3'b000, 0, 1'b0, 2};
    vecs[11] = '{3'b100, 3'b100, 1, 3'b000, 0, 1'b1, 2};
    vecs[12] = '{3'b101, 3'b100, 3, 3'b000, 0, 1'b0, 9};

    // Reset state.
    #1;
    checkOutput("reset_hit", {31'd0, hit}, 32'd0);
    checkOutput("reset_miss", {31'd0, miss}, 32'd0);
    checkOutput("reset_score", {22'd0, score}, 32'd0);
    checkOutput("reset_combo", {24'd0, combo}, 32'd0);
    checkOutput("reset_judging", {31'd0, judging}, 32'd0);
    repeat (3) step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    // Tick while armed with an incomplete beat: old one misses, new one hits.
    step();
    tick = 1'b1; pattern = 3'b101; keys = 3'b000;
    step();
    tick = 1'b0; keys = 3'b100;
    step();
    step();
    tick = 1'b1; pattern = 3'b010; t1 = cyc;
    pushExpect(1'b0, t1 + 1);
    step();
    tick = 1'b0;
    checkOutput("retick_judging", {31'd0, judging}, 32'd1);
    step();
    keys = 3'b110;
    pushExpect(1'b1, cyc + 1);
    repeat (3) step();
    keys = 3'b000;
    repeat (3) step();

    // Tick in the very cycle the window expires still arms the next beat.
    step();
    tick = 1'b1; pattern = 3'b001; keys = 3'b000; t0 = cyc;
    pushExpect(1'b0, t0 + WINDOW + 1);
    repeat (WINDOW - 1) begin
      step();
      tick = 1'b0;
    end
    step();
    tick = 1'b1; pattern = 3'b100;
    step();
    tick = 1'b0; keys = 3'b100;
    pushExpect(1'b1, cyc + 1);
    repeat (2) step();
    keys = 3'b000;
    repeat (3) step();

    // Edge in the retick cycle belongs to the old beat.
    step();
    tick = 1'b1; pattern = 3'b100; keys = 3'b000;
    step();
    tick = 1'b0;
    step();
    tick = 1'b1; pattern = 3'b010; keys = 3'b100;
    pushExpect(1'b1, cyc + 1);
    step();
    tick = 1'b0;
    step();
    keys = 3'b110;
    pushExpect(1'b1, cyc + 1);
    repeat (2) step();
    keys = 3'b000;
    repeat (3) step();

    // Key held across the tick alone never hits; the beat times out.
    step();
    keys = 3'b001;
    step();
    tick = 1'b1; pattern = 3'b001; t0 = cyc;
    pushExpect(1'b0, t0 + WINDOW + 1);
    repeat (12) begin
      step();
      tick = 1'b0;
    end
    keys = 3'b000;
    repeat (2) step();

    // Held across the tick, released, pressed again: the re-press hits.
    keys = 3'b001;
    step();
    tick = 1'b1; pattern = 3'b001; t0 = cyc;
    step();
    tick = 1'b0;
    step();
    keys = 3'b000;
    step();
    keys = 3'b001;
    pushExpect(1'b1, t0 + 4);
    repeat (3) step();
    keys = 3'b000;
    repeat (2) step();

    // Three hits, then reset pulled mid-window discards the armed beat.
    fastHits(3);
    step();
    tick = 1'b1; pattern = 3'b010; keys = 3'b000;
    step();
    tick = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_hit", {31'd0, hit}, 32'd0);
    checkOutput("midreset_miss", {31'd0, miss}, 32'd0);
    checkOutput("midreset_score", {22'd0, score}, 32'd0);
    checkOutput("midreset_combo", {24'd0, combo}, 32'd0);
    checkOutput("midreset_judging", {31'd0, judging}, 32'd0);
    exp_score = 0;
    exp_combo = 0;
    repeat (2) step();
    reset = 1'b1;
    step();
    keys = 3'b010;
    repeat (12) step();
    keys = 3'b000;
    step();
    checkOutput("postreset_judging", {31'd0, judging}, 32'd0);

    // Enough hits to saturate both score and combo.
    fastHits(SCORE_MAX + 7);
    checkOutput("sat_score", {22'd0, score}, SCORE_MAX);
    checkOutput("sat_combo", {24'd0, combo}, COMBO_MAX);

    repeat (20) step();
    checkOutput("queue_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Bound on the whole run in case the stimulus ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lane_judge.md
Name: lane_judge

Overview:
- Judges player key presses against the lane pattern shown on the 3-lane LED display of the rhythm game.
- Receives the 3-bit light pattern plus a beat strobe from the lane-light FSM side, and the three player keys.
- Emits hit/miss pulses and keeps a running score and combo for the HEX display logic.
- Counterpart of the light generator: it consumes the pattern that the light generator produces.

Parameters:
- WINDOW, 8, hit window length in clk cycles after a beat strobe (legal range 1..255).
- SCORE_W, 10, score counter width.
- COMBO_W, 8, combo counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- pattern  input  3  current lane pattern; legal values 101, 001, 100, 010; bit2 = left lane, bit0 = right lane.
- tick  input  1  one-cycle beat strobe; pattern is valid and stable in the tick cycle.
- keys  input  3  player keys, already synchronised, 1 = pressed, same bit order as pattern.
- hit  output  1  one-cycle pulse: beat judged correct.
- miss  output  1  one-cycle pulse: beat judged wrong or expired.
- score  output  SCORE_W  count of hits, saturating.
- combo  output  COMBO_W  consecutive hits since the last miss, saturating.
- judging  output  1  high while a beat is armed (ARMED state).

Behaviour:
- Reset (reset = 0, asynchronous):
  - State = IDLE.
  - target, acc, keys_prev, window counter all cleared to 0.
  - hit = 0, miss = 0, score = 0, combo = 0, judging = 0.
  - Reset is honoured mid-beat: any pending judgment is discarded and no pulse is emitted.
- Edge detect:
  - edges = keys & ~keys_prev.
  - keys_prev <= keys every cycle, in all states.
  - Only rising edges count. A key held across a tick produces no edge for the new beat.
- States: IDLE, ARMED, DONE.
  - IDLE --tick--> ARMED.
  - ARMED --judgment--> DONE.
  - ARMED --tick--> ARMED (old beat is judged first, then the new beat is armed).
  - DONE --tick--> ARMED.
- Arming on tick:
  - target <= pattern; acc <= 0; cnt <= WINDOW-1.
  - judging is high from the cycle after the tick.
- In ARMED, with no tick, each cycle:
  - nacc = acc | edges.
  - If nacc has any bit outside target: miss; go to DONE.
  - Else if nacc == target: hit; go to DONE.
  - Else if cnt == 0: miss; go to DONE.
  - Else acc <= nacc; cnt <= cnt-1.
  - Mismatch takes priority over match when both could apply in the same cycle.
  - Multi-lane target (101): both keys may rise in the same cycle or in different cycles inside the window.
- Tick while ARMED (including the cycle the window expires):
  - The old beat is judged with the same rules, using nacc, except that an incomplete nacc counts as a miss.
  - Edges in that cycle are consumed by the old beat.
  - The new beat is then armed as above.
- Keys in IDLE or DONE are ignored; no penalty.
- Outputs are registered:
  - hit/miss pulse exactly one cycle, in the cycle after the deciding edge.
  - hit and miss are never high together.
  - Worst-case latency tick -> miss is WINDOW+1 cycles.
- On hit: score <= score+1, saturating at all-ones; combo <= combo+1, saturating at all-ones.
- On miss: combo <= 0; score unchanged.
- tick with pattern outside the 4 legal values: arm anyway; the beat can only end in a miss.

Test Plan:
- Reset, tick with pattern=010, rise keys=010 two cycles later -> one-cycle hit, score=1, combo=1, judging low afterwards.
- tick with pattern=101, keys=100 rises, keys=101 one cycle later -> single hit after the second edge; score increments by 1 only.
- tick with pattern=001, no keys, WINDOW=8 -> miss exactly 9 cycles after the tick; combo=0; score unchanged.
- tick with pattern=100, keys=010 rises -> immediate miss; a later press of 100 in the same window produces no pulse.
- Hold keys=001 across a tick with pattern=001, release, press again -> only the re-press hits; the held key alone times out with a miss.
- After 3 hits, assert reset low mid-window -> all outputs 0 immediately (asynchronously); no pulse after release. Also: force score to all-ones, then hit -> score stays at max.
